// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single-ported word memory.
// Data wins by default; instruction wins after STARVE_MAX consecutive lost cycles.
module mem_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int MEM_WORDS  = 32768,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_rready,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_wready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic              exception
);
  localparam logic [1:0]        IDLE  = 2'd0;
  localparam logic [1:0]        RSP_I = 2'd1;
  localparam logic [1:0]        RSP_D = 2'd2;
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [2:0]        SMAX  = 3'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [2:0]        starve_cnt_q, starve_cnt_d;
  logic              exception_q, exception_d;
  logic              rsp_oor_q, rsp_oor_d;
  logic [ADDR_W-1:0] sel_addr;
  logic              in_range;

  always_comb begin
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    mem_rready   = 1'b0;
    mem_raddr    = '0;
    mem_wready   = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    state_d      = IDLE;
    rsp_oor_d    = 1'b0;
    exception_d  = exception_q;
    starve_cnt_d = 3'd0;

    i_gnt    = !resetb && i_req && (!d_req || starve_cnt_q == SMAX);
    d_gnt    = !resetb && d_req && !i_gnt;
    sel_addr = i_gnt ? i_addr : d_addr;
    in_range = {1'b0, sel_addr} < LIMIT;

    if (i_gnt || d_gnt) begin
      // Out-of-range accesses are still granted and answered, but never reach memory.
      if (!in_range) begin
        exception_d = 1'b1;
      end else if (d_gnt && d_we) begin
        mem_wready = 1'b1;
        mem_waddr  = d_addr;
        mem_wdata  = d_wdata;
        mem_wstrb  = d_wstrb;
      end else begin
        mem_rready = 1'b1;
        mem_raddr  = sel_addr;
      end
      if (i_gnt) state_d = RSP_I;
      else if (!d_we) state_d = RSP_D;
      rsp_oor_d = !in_range;
    end

    if (i_req && !i_gnt)
      starve_cnt_d = (starve_cnt_q == SMAX) ? starve_cnt_q : starve_cnt_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q      <= IDLE;
      starve_cnt_q <= 3'd0;
      exception_q  <= 1'b0;
      rsp_oor_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      exception_q  <= exception_d;
      rsp_oor_q    <= rsp_oor_d;
    end
  end

  assign exception = exception_q;
  assign i_rvalid  = (state_q == RSP_I);
  assign d_rvalid  = (state_q == RSP_D);
  assign i_rdata   = (i_rvalid && !rsp_oor_q) ? mem_rdata : 32'h0;
  assign d_rdata   = (d_rvalid && !rsp_oor_q) ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small word-memory model (mem[a] preloaded to 0x1000_0000+a).
module tb_mem_arbiter;
  localparam int ADDR_W = 30;

  logic              clk = 1'b0;
  logic              resetb;
  logic              i_req, d_req, d_we;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;
  logic              i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0]       i_rdata, d_rdata;
  logic              mem_rready, mem_wready, exception;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:255];

  mem_arbiter dut (
    .clk(clk), .resetb(resetb),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_rready(mem_rready), .mem_raddr(mem_raddr), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .exception(exception)
  );

  always #5 clk = ~clk;

  // Memory returns junk when not read so ungated rdata paths are visible.
  always @(posedge clk) begin
    mem_rdata <= mem_rready ? mem[mem_raddr[7:0]] : 32'hDEADBEEF;
    if (mem_wready)
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_waddr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + k;
    resetb = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 30'h10; d_addr = 30'h20; d_wdata = '0; d_wstrb = '0;

    // Grants suppressed while reset is asserted
    @(negedge clk);
    chk("rst_i_gnt", 32'(i_gnt), 0);
    chk("rst_d_gnt", 32'(d_gnt), 0);
    chk("rst_rready", 32'(mem_rready), 0);
    cyc(); i_req = 1'b0; d_req = 1'b0;
    cyc(); resetb = 1'b0;
    @(negedge clk);
    chk("por_i_rvalid", 32'(i_rvalid), 0);
    chk("por_d_rvalid", 32'(d_rvalid), 0);
    chk("por_i_rdata", i_rdata, 0);
    chk("por_d_rdata", d_rdata, 0);
    chk("por_exc", 32'(exception), 0);
    chk("idle_raddr", 32'(mem_raddr), 0);
    chk("idle_wready", 32'(mem_wready), 0);

    // Single instruction read of 0x10
    cyc(); i_req = 1'b1; i_addr = 30'h10;
    @(negedge clk);
    chk("i_gnt", 32'(i_gnt), 1);
    chk("i_d_gnt", 32'(d_gnt), 0);
    chk("i_rready", 32'(mem_rready), 1);
    chk("i_raddr", 32'(mem_raddr), 32'h10);
    chk("i_wready", 32'(mem_wready), 0);
    cyc(); i_req = 1'b0;
    @(negedge clk);
    chk("i_rvalid", 32'(i_rvalid), 1);
    chk("i_rdata", i_rdata, 32'h1000_0010);
    chk("i_d_rvalid", 32'(d_rvalid), 0);

    // Partial write then read-back
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wstrb = 4'b0011; d_wdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("w_gnt", 32'(d_gnt), 1);
    chk("w_wready", 32'(mem_wready), 1);
    chk("w_rready", 32'(mem_rready), 0);
    chk("w_waddr", 32'(mem_waddr), 32'h20);
    chk("w_wdata", mem_wdata, 32'hAABBCCDD);
    chk("w_wstrb", 32'(mem_wstrb), 32'h3);
    cyc(); d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("w_no_rvalid", 32'(d_rvalid), 0);
    cyc(); d_req = 1'b1;
    @(negedge clk);
    chk("rb_gnt", 32'(d_gnt), 1);
    chk("rb_rready", 32'(mem_rready), 1);
    cyc(); d_req = 1'b0;
    @(negedge clk);
    chk("rb_rvalid", 32'(d_rvalid), 1);
    chk("rb_rdata", d_rdata, 32'h1000_CCDD);

    // Both ports held: 4 data grants then 1 instruction grant, repeating
    cyc(); i_req = 1'b1; i_addr = 30'h1; d_req = 1'b1; d_addr = 30'h2;
    begin
      logic prev_i;
      prev_i = 1'b0;
      for (int k = 0; k < 10; k++) begin
        logic exp_i;
        exp_i = (k % 5 == 4);
        @(negedge clk);
        chk($sformatf("st_i_gnt%0d", k), 32'(i_gnt), 32'(exp_i));
        chk($sformatf("st_d_gnt%0d", k), 32'(d_gnt), 32'(!exp_i));
        if (k > 0) begin
          chk($sformatf("st_i_rv%0d", k), 32'(i_rvalid), 32'(prev_i));
          chk($sformatf("st_d_rd%0d", k), d_rdata, prev_i ? 32'h0 : 32'h1000_0002);
          chk($sformatf("st_i_rd%0d", k), i_rdata, prev_i ? 32'h1000_0001 : 32'h0);
        end
        prev_i = exp_i;
        cyc();
      end
    end
    i_req = 1'b0; d_req = 1'b0;

    // Out-of-range instruction read and data write
    cyc(); i_req = 1'b1; i_addr = 30'h8000;
    @(negedge clk);
    chk("oor_i_gnt", 32'(i_gnt), 1);
    chk("oor_rready", 32'(mem_rready), 0);
    cyc(); i_req = 1'b0;
    @(negedge clk);
    chk("oor_rvalid", 32'(i_rvalid), 1);
    chk("oor_rdata", i_rdata, 32'h0);
    chk("oor_exc", 32'(exception), 1);
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 30'h9000; d_wstrb = 4'hF;
    @(negedge clk);
    chk("oorw_gnt", 32'(d_gnt), 1);
    chk("oorw_wready", 32'(mem_wready), 0);
    cyc(); d_req = 1'b0; d_we = 1'b0;
    cyc();
    @(negedge clk);
    chk("oor_exc_sticky", 32'(exception), 1);

    // Read granted, then reset: response dropped, exception cleared
    cyc(); d_req = 1'b1; d_addr = 30'h5;
    @(negedge clk);
    chk("pre_rst_gnt", 32'(d_gnt), 1);
    cyc(); d_req = 1'b0; resetb = 1'b1;
    cyc(); resetb = 1'b0; i_req = 1'b1; i_addr = 30'h3;
    @(negedge clk);
    chk("rst_drop_rvalid", 32'(d_rvalid), 0);
    chk("rst_exc_clr", 32'(exception), 0);
    chk("post_rst_i_gnt", 32'(i_gnt), 1);
    cyc(); i_req = 1'b0;
    @(negedge clk);
    chk("post_rst_rdata", i_rdata, 32'h1000_0003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 30, sets the word-address width of every address port.
REQ-002 Parameter MEM_WORDS, default 32768 (128 KiB), sets the number of legal word addresses.
REQ-003 Parameter STARVE_MAX, default 4, sets the consecutive lost cycles after which the instruction port wins.
REQ-004 The block SHALL use one clock, clk; reset is resetb, synchronous and active-high (resetb=1 resets on the clk rising edge).
REQ-005 Ports, listed as name, direction, width, meaning:
- clk  in  1  clock.
- resetb  in  1  synchronous active-high reset.
- i_req  in  1  instruction read request.
- i_addr  in  ADDR_W  instruction word address.
- i_gnt  out  1  instruction request accepted this cycle.
- i_rvalid  out  1  instruction read data valid.
- i_rdata  out  32  instruction read data.
- d_req  in  1  data request.
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  32  write data.
- d_wstrb  in  4  byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid.
- d_rdata  out  32  data read data.
- mem_rready  out  1  memory read strobe.
- mem_raddr  out  ADDR_W  memory read address.
- mem_wready  out  1  memory write strobe.
- mem_waddr  out  ADDR_W  memory write address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte enables.
- mem_rdata  in  32  memory read data, valid 1 cycle after mem_rready.
- exception  out  1  sticky out-of-range access flag.

Function
REQ-006 At most one request SHALL be granted per cycle; i_gnt and d_gnt are combinational and never both 1.
REQ-007 Priority: d_req wins over i_req unless starve_cnt==STARVE_MAX, in which case i_req wins.
REQ-008 starve_cnt (3-bit) SHALL increment, saturating at STARVE_MAX, each cycle i_req=1 and i_gnt=0; it clears to 0 on i_gnt or when i_req=0.
REQ-009 A granted in-range read SHALL drive mem_rready=1 and mem_raddr=the requester address in the grant cycle; mem_wready=0.
REQ-010 A granted in-range write (d_we=1) SHALL drive mem_wready=1, with mem_waddr/mem_wdata/mem_wstrb equal to d_addr/d_wdata/d_wstrb in the same cycle; the write completes in that cycle and no rvalid follows.
REQ-011 The response FSM SHALL have states IDLE, RSP_I and RSP_D, updated every cycle: next=RSP_I on an instruction grant, RSP_D on a data read grant, IDLE otherwise (no grant, or a data write).
REQ-012 In RSP_I, i_rvalid=1 and i_rdata=mem_rdata; in RSP_D, d_rvalid=1 and d_rdata=mem_rdata; unselected rvalid=0 and rdata=0.
REQ-013 Back-to-back grants SHALL be accepted every cycle: throughput 1 access/cycle, read latency exactly 1 cycle after grant.
REQ-014 A granted request with address >= MEM_WORDS SHALL NOT assert mem_rready or mem_wready; it sets exception=1 (sticky); a read still returns rvalid after 1 cycle with rdata=32'h0.
REQ-015 When no request is granted, mem_rready=0, mem_wready=0, and all mem address/data/strobe outputs=0.

Reset
REQ-016 While resetb=1: i_gnt=0, d_gnt=0, mem_rready=0, mem_wready=0, regardless of requests.
REQ-017 After a reset edge: FSM=IDLE, starve_cnt=0, exception=0, i_rvalid=d_rvalid=0, i_rdata=d_rdata=0.
REQ-018 A read granted in the cycle before reset SHALL be discarded: no rvalid in the cycle after the reset edge.

Verification
REQ-019 Only i_req=1, i_addr=0x10 -> i_gnt=1 and mem_raddr=0x10 in the same cycle; next cycle i_rvalid=1 and i_rdata=mem[0x10].
REQ-020 i_req and d_req (read) held high continuously -> d wins for 4 cycles, the 5th cycle grants i, then the pattern repeats; gnt is never both 1.
REQ-021 d_req=1, d_we=1, d_addr=0x20, d_wstrb=4'b0011, d_wdata=0xAABBCCDD -> mem_wready=1 with those values the same cycle; no d_rvalid the next cycle; a later read of 0x20 returns low 16 bits 0xCCDD.
REQ-022 i_addr=0x8000 (>= MEM_WORDS) -> i_gnt=1 with mem_rready=0; next cycle i_rvalid=1 and i_rdata=0; exception stays 1 until reset.
REQ-023 d read granted, then resetb=1 on the next edge -> d_rvalid=0 after reset, exception=0, and the first post-reset i_req is granted immediately.
